// File: rtl/ntt_xstage_bfly_param.sv
// rtl/ntt_xstage_bfly_param.sv - parametrised NTT X-stage modular add/sub butterfly between FIFO streams
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   ap_start/ap_done/ap_idle/ap_ready  frame handshake (done and ready pulse together)
//   mode_bypass                     latched at accepted ap_start; 1 = pass words through unchanged
//   in_dout/in_empty_n/in_read      NCH input FIFO channels, word k at [k*(DW+1) +: DW+1]
//   out_din/out_full_n/out_write    NCH output FIFO channels, same packing
//   beat_count                      beats read in the current or last frame
//   err                             sticky beat error, cleared by an accepted ap_start
module ntt_xstage_bfly_param #(
  parameter int              NCH         = 4,
  parameter int              DW          = 64,
  parameter int              QW          = 32,
  parameter longint unsigned Q           = 64'd3221225473,
  parameter int              FRAME_BEATS = 256,
  parameter int              CW          = $clog2(FRAME_BEATS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic                  ap_ready,
  input  logic                  mode_bypass,
  input  logic [NCH*(DW+1)-1:0] in_dout,
  input  logic [NCH-1:0]        in_empty_n,
  output logic [NCH-1:0]        in_read,
  output logic [NCH*(DW+1)-1:0] out_din,
  input  logic [NCH-1:0]        out_full_n,
  output logic [NCH-1:0]        out_write,
  output logic [CW-1:0]         beat_count,
  output logic                  err
);

  localparam int              WW   = DW + 1;
  localparam int              HALF = NCH / 2;
  localparam logic [QW:0]     Q_X  = (QW+1)'(Q);
  localparam logic [DW-1:0]   Q_D  = DW'(Q);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state, state_nxt;

  logic                   bypass_q;
  logic                   s1_valid, s2_valid;
  logic [NCH-1:0][WW-1:0] s1_word, s2_word;
  logic [NCH-1:0][WW-1:0] s1_word_nxt, s2_word_nxt;
  logic [NCH-1:0][WW-1:0] in_words;
  logic [HALF-1:0][QW:0]  bf_sum, bf_diff, red_sum, red_diff;
  logic rd, adv2, s2_open, s1_move, s1_can_accept;
  logic in_last, last_mismatch, operand_bad, beat_err, end_of_frame;

  assign in_words      = in_dout;
  assign in_last       = in_words[0][DW];

  // Handshake chain: s2 drains to the outputs, s1 refills s2, the input refills s1.
  assign adv2          = s2_valid & (&out_full_n);
  assign s2_open       = !s2_valid | adv2;
  assign s1_move       = s1_valid & s2_open;
  assign s1_can_accept = !s1_valid | s1_move;
  assign rd            = (state == S_RUN) & (&in_empty_n) & s1_can_accept;

  assign in_read   = {NCH{rd}};
  assign out_write = {NCH{adv2}};
  assign out_din   = s2_word;
  assign ap_idle   = (state == S_IDLE);
  assign ap_done   = (state == S_DONE);
  assign ap_ready  = (state == S_DONE);

  always_comb begin
    last_mismatch = 1'b0;
    operand_bad   = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (in_words[k][DW] != in_last) last_mismatch = 1'b1;
      // Covers both an operand >= Q and stray bits above the modulus width.
      if (in_words[k][DW-1:0] >= Q_D) operand_bad = 1'b1;
    end
  end

  assign beat_err     = last_mismatch | (operand_bad & !bypass_q);
  assign end_of_frame = in_last | (beat_count == CW'(FRAME_BEATS - 1));

  // Stage 1: raw sum and difference in QW+1 bits; bit QW of the difference is its sign.
  always_comb begin
    for (int i = 0; i < HALF; i++) begin
      bf_sum[i]  = {1'b0, in_words[i][QW-1:0]} + {1'b0, in_words[i+HALF][QW-1:0]};
      bf_diff[i] = {1'b0, in_words[i][QW-1:0]} - {1'b0, in_words[i+HALF][QW-1:0]};
    end
  end

  always_comb begin
    for (int k = 0; k < NCH; k++) s1_word_nxt[k] = {in_last, in_words[k][DW-1:0]};
    if (!bypass_q) begin
      for (int i = 0; i < HALF; i++) begin
        s1_word_nxt[i]      = {in_last, DW'(bf_sum[i])};
        s1_word_nxt[i+HALF] = {in_last, DW'(bf_diff[i])};
      end
    end
  end

  // Stage 2: single conditional correction brings both results back into [0, Q).
  always_comb begin
    for (int i = 0; i < HALF; i++) begin
      red_sum[i]  = (s1_word[i][QW:0] >= Q_X) ? s1_word[i][QW:0] - Q_X : s1_word[i][QW:0];
      red_diff[i] = s1_word[i+HALF][QW] ? s1_word[i+HALF][QW:0] + Q_X : s1_word[i+HALF][QW:0];
    end
  end

  always_comb begin
    for (int k = 0; k < NCH; k++) s2_word_nxt[k] = s1_word[k];
    if (!bypass_q) begin
      for (int i = 0; i < HALF; i++) begin
        s2_word_nxt[i]      = {s1_word[i][DW], DW'(red_sum[i])};
        s2_word_nxt[i+HALF] = {s1_word[i+HALF][DW], DW'(red_diff[i])};
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ap_start) state_nxt = S_RUN;
      S_RUN:   if (rd && end_of_frame) state_nxt = S_DRAIN;
      S_DRAIN: if (!s1_valid && !s2_valid) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      bypass_q   <= 1'b0;
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s1_word    <= '0;
      s2_word    <= '0;
      beat_count <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && ap_start) begin
        bypass_q   <= mode_bypass;
        beat_count <= '0;
        err        <= 1'b0;
      end
      if (rd) begin
        beat_count <= beat_count + CW'(1);
        if (beat_err) err <= 1'b1;
        s1_word <= s1_word_nxt;
      end
      if (s1_can_accept) s1_valid <= rd;
      if (s2_open) s2_valid <= s1_valid;
      if (s1_move) s2_word <= s2_word_nxt;
    end
  end

endmodule

// File: tb/tb_ntt_xstage_bfly_param.sv
// tb/tb_ntt_xstage_bfly_param.sv - self-checking bench for ntt_xstage_bfly_param
module tb_ntt_xstage_bfly_param;

  localparam int              NCH         = 4;
  localparam int              DW          = 64;
  localparam int              QW          = 32;
  localparam longint unsigned Q           = 64'd3221225473;
  localparam int              FRAME_BEATS = 256;
  localparam int              CW          = $clog2(FRAME_BEATS + 1);
  localparam int              WW          = DW + 1;

  typedef logic [NCH-1:0][WW-1:0] beat_t;
  typedef logic [NCH-1:0][63:0]   word4_t;

  typedef struct {
    word4_t din;
    bit     byp;
    bit     chk;
    word4_t dout;
    bit     exp_err;
  } vec_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  ap_start;
  logic                  ap_done, ap_idle, ap_ready;
  logic                  mode_bypass;
  logic [NCH*WW-1:0]     in_dout;
  logic [NCH-1:0]        in_empty_n;
  logic [NCH-1:0]        in_read;
  logic [NCH*WW-1:0]     out_din;
  logic [NCH-1:0]        out_full_n;
  logic [NCH-1:0]        out_write;
  logic [CW-1:0]         beat_count;
  logic                  err;

  always #5 clk = ~clk;

  ntt_xstage_bfly_param #(
    .NCH(NCH), .DW(DW), .QW(QW), .Q(Q), .FRAME_BEATS(FRAME_BEATS)
  ) dut (
    .clk(clk), .reset(reset), .ap_start(ap_start), .ap_done(ap_done),
    .ap_idle(ap_idle), .ap_ready(ap_ready), .mode_bypass(mode_bypass),
    .in_dout(in_dout), .in_empty_n(in_empty_n), .in_read(in_read),
    .out_din(out_din), .out_full_n(out_full_n), .out_write(out_write),
    .beat_count(beat_count), .err(err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int reads = 0;
  int writes = 0;
  int stall_reads = 0;
  int last_lat = 0;
  beat_t src_q[$];
  beat_t exp_q[$];
  bit    dc_q[$];
  int    rd_cyc_q[$];
  bit    byp_cur, err_model;
  bit    empty_stall, rand_stall;
  logic [NCH-1:0] full_mask;
  bit    done_seen, ready_seen, err_seen;
  beat_t last_out;
  vec_t  vecs [8];

  task automatic check(input bit ok, input string name, input longint unsigned act, input longint unsigned req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic word4_t w4(input logic [63:0] c0, c1, c2, c3);
    word4_t r;
    r[0] = c0; r[1] = c1; r[2] = c2; r[3] = c3;
    return r;
  endfunction

  function automatic beat_t mk_beat(input word4_t d, input bit last);
    beat_t b;
    for (int k = 0; k < NCH; k++) b[k] = {last, d[k]};
    return b;
  endfunction

  // Reference: out[i] = (a+b) mod Q, out[i+H] = (a-b) mod Q, last from channel 0.
  function automatic beat_t ref_beat(input beat_t ib, input bit byp);
    beat_t r;
    longint unsigned a, b;
    logic l;
    l = ib[0][DW];
    for (int k = 0; k < NCH; k++) r[k] = {l, ib[k][DW-1:0]};
    if (!byp) begin
      for (int i = 0; i < NCH/2; i++) begin
        a = 64'(ib[i][QW-1:0]);
        b = 64'(ib[i+NCH/2][QW-1:0]);
        r[i]         = {l, 64'((a + b) % Q)};
        r[i+NCH/2]   = {l, 64'((a + Q - b) % Q)};
      end
    end
    return r;
  endfunction

  function automatic bit beat_is_err(input beat_t ib, input bit byp);
    bit e;
    e = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (ib[k][DW] != ib[0][DW]) e = 1'b1;
      if (!byp && 64'(ib[k][DW-1:0]) >= Q) e = 1'b1;
    end
    return e;
  endfunction

  task automatic drive_inputs();
    if (rand_stall) begin
      empty_stall = ($urandom_range(0, 3) == 0);
      full_mask   = ($urandom_range(0, 3) == 0) ? (4'hF ^ 4'(1 << $urandom_range(0, 3))) : 4'hF;
    end
    out_full_n = full_mask;
    if (src_q.size() > 0) begin
      in_dout    = src_q[0];
      in_empty_n = empty_stall ? 4'($urandom_range(0, 14)) : 4'hF;
    end else begin
      in_dout    = '0;
      in_empty_n = '0;
    end
  endtask

  // One clock: sample at the falling edge, then drive new inputs just after the rising edge.
  task automatic tick();
    logic [NCH-1:0] rd, wr;
    beat_t ob, ib, e;
    bit dc;
    @(negedge clk);
    rd = in_read; wr = out_write; ob = out_din;
    done_seen = ap_done; ready_seen = ap_ready; err_seen = err;
    check(rd == '0 || rd == '1, "in_read_all_or_none", 64'(rd), 15);
    check(wr == '0 || wr == '1, "out_write_all_or_none", 64'(wr), 15);
    check(rd == '0 || in_empty_n == '1, "read_while_empty", 64'(in_empty_n), 15);
    check(wr == '0 || out_full_n == '1, "write_while_full", 64'(out_full_n), 15);
    if (rd == '1 && src_q.size() > 0) begin
      ib = src_q.pop_front();
      reads++;
      if (out_full_n != '1) stall_reads++;
      exp_q.push_back(ref_beat(ib, byp_cur));
      dc_q.push_back(beat_is_err(ib, byp_cur));
      if (beat_is_err(ib, byp_cur)) err_model = 1'b1;
      rd_cyc_q.push_back(cyc);
    end
    if (wr == '1) begin
      writes++;
      last_out = ob;
      check(exp_q.size() > 0, "write_without_read", 64'(writes), 64'(reads));
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        dc = dc_q.pop_front();
        last_lat = cyc - rd_cyc_q.pop_front();
        if (!dc) begin
          for (int k = 0; k < NCH; k++) begin
            check(ob[k][DW-1:0] == e[k][DW-1:0], $sformatf("out_ch%0d_data", k), ob[k][DW-1:0], e[k][DW-1:0]);
            check(ob[k][DW] == e[k][DW], $sformatf("out_ch%0d_last", k), 64'(ob[k][DW]), 64'(e[k][DW]));
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    drive_inputs();
  endtask

  task automatic run_frame(input bit byp, input int exp_reads, input int stall_at, input int poke_at, input string nm);
    int r0, w0, budget, it;
    r0 = reads; w0 = writes; stall_reads = 0;
    err_model = 1'b0; byp_cur = byp;
    mode_bypass = byp; ap_start = 1'b1;
    drive_inputs();
    tick();
    ap_start = 1'b0; mode_bypass = ~byp;
    check(err == 1'b0, {nm, "_err_cleared_on_start"}, 64'(err), 0);
    check(ap_idle == 1'b0, {nm, "_left_idle"}, 64'(ap_idle), 0);
    budget = 3000; it = 0; done_seen = 1'b0;
    while (!done_seen && budget > 0) begin
      it++;
      if (stall_at >= 0 && !rand_stall) full_mask = (it > stall_at && it <= stall_at + 5) ? 4'b1101 : 4'hF;
      ap_start = (it == poke_at);
      tick();
      budget--;
    end
    ap_start = 1'b0;
    full_mask = 4'hF;
    check(budget > 0, {nm, "_done_timeout"}, 64'(budget), 1);
    check(ready_seen == 1'b1, {nm, "_ready_with_done"}, 64'(ready_seen), 1);
    check(err_seen == err_model, {nm, "_err_at_done"}, 64'(err_seen), 64'(err_model));
    check(ap_idle == 1'b1, {nm, "_idle_after_done"}, 64'(ap_idle), 1);
    check(ap_done == 1'b0, {nm, "_done_single_pulse"}, 64'(ap_done), 0);
    check(reads - r0 == exp_reads, {nm, "_reads"}, 64'(reads - r0), 64'(exp_reads));
    check(writes - w0 == exp_reads, {nm, "_writes"}, 64'(writes - w0), 64'(exp_reads));
    check(beat_count == CW'(exp_reads), {nm, "_beat_count"}, 64'(beat_count), 64'(exp_reads));
    check(err == err_model, {nm, "_err_held"}, 64'(err), 64'(err_model));
    if (stall_at >= 0) check(stall_reads <= 2, {nm, "_reads_during_stall"}, 64'(stall_reads), 2);
  endtask

  function automatic word4_t rand_ops(input bit wide);
    word4_t r;
    for (int k = 0; k < NCH; k++) begin
      if (wide) r[k] = {$urandom, $urandom};
      else case ($urandom_range(0, 5))
        0:       r[k] = 64'd0;
        1:       r[k] = Q - 1;
        default: r[k] = 64'($urandom_range(0, 32'(Q - 1)));
      endcase
    end
    return r;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, w0, budget;
    word4_t d;
    reset = 1'b1; ap_start = 1'b0; mode_bypass = 1'b0;
    in_dout = '0; in_empty_n = '0; out_full_n = '1;
    full_mask = '1; empty_stall = 1'b0; rand_stall = 1'b0;

    vecs[0] = '{w4(64'd5, Q - 1, 64'd3, 64'd1), 1'b0, 1'b1, w4(64'd8, 64'd0, 64'd2, 64'd3221225471), 1'b0};
    vecs[1] = '{w4(64'd3, 64'd0, 64'd5, 64'd0), 1'b0, 1'b1, w4(64'd8, 64'd0, 64'd3221225471, 64'd0), 1'b0};
    vecs[2] = '{w4(64'd0, 64'd0, 64'd0, 64'd0), 1'b0, 1'b1, w4(64'd0, 64'd0, 64'd0, 64'd0), 1'b0};
    vecs[3] = '{w4(64'd0, 64'd3221225473, 64'd0, 64'd0), 1'b0, 1'b0, w4(64'd0, 64'd0, 64'd0, 64'd0), 1'b1};
    vecs[4] = '{w4(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF), 1'b1, 1'b1,
                w4(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF), 1'b0};
    vecs[5] = '{w4(Q - 1, Q - 1, Q - 1, Q - 1), 1'b0, 1'b1, w4(64'd3221225471, 64'd3221225471, 64'd0, 64'd0), 1'b0};
    vecs[6] = '{w4(64'd1, 64'd2, 64'd3, 64'h1_0000_0002), 1'b0, 1'b0, w4(64'd0, 64'd0, 64'd0, 64'd0), 1'b1};
    vecs[7] = '{w4(64'd3221225473, 64'h100_0000_0000, 64'd7, 64'd0), 1'b1, 1'b1,
                w4(64'd3221225473, 64'h100_0000_0000, 64'd7, 64'd0), 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check(ap_idle == 1'b1, "reset_ap_idle", 64'(ap_idle), 1);
    check(ap_done == 1'b0, "reset_ap_done", 64'(ap_done), 0);
    check(ap_ready == 1'b0, "reset_ap_ready", 64'(ap_ready), 0);
    check(in_read == '0, "reset_in_read", 64'(in_read), 0);
    check(out_write == '0, "reset_out_write", 64'(out_write), 0);
    check(out_din == '0, "reset_out_din_zero", 64'(|out_din), 0);
    check(beat_count == '0, "reset_beat_count", 64'(beat_count), 0);
    check(err == 1'b0, "reset_err", 64'(err), 0);
    reset = 1'b0;
    drive_inputs();
    @(posedge clk);
    #1;

    // Single-beat frames from the vector table.
    for (int i = 0; i < 8; i++) begin
      src_q.push_back(mk_beat(vecs[i].din, 1'b1));
      run_frame(vecs[i].byp, 1, -1, -1, $sformatf("vec%0d", i));
      check(err == vecs[i].exp_err, $sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
      if (vecs[i].chk) begin
        for (int k = 0; k < NCH; k++)
          check(last_out[k] == {1'b1, vecs[i].dout[k]}, $sformatf("vec%0d_ch%0d", i, k), last_out[k][DW-1:0], vecs[i].dout[k]);
        check(last_lat == 2, $sformatf("vec%0d_latency", i), 64'(last_lat), 2);
      end
    end

    // Eight beats with channel 1 backpressured mid-frame.
    for (int b = 0; b < 8; b++) src_q.push_back(mk_beat(rand_ops(1'b0), b == 7));
    run_frame(1'b0, 8, 4, -1, "backpressure");

    // Last flag on beat 3; the two beats behind it must stay in the FIFO.
    for (int b = 0; b < 5; b++) src_q.push_back(mk_beat(rand_ops(1'b0), b == 2));
    run_frame(1'b0, 3, -1, -1, "early_last");
    check(src_q.size() == 2, "early_last_left_in_fifo", 64'(src_q.size()), 2);
    src_q.delete();

    // Full-length frame under random stalls, with a stray ap_start mid-frame.
    rand_stall = 1'b1;
    for (int b = 0; b < FRAME_BEATS + 4; b++) src_q.push_back(mk_beat(rand_ops(1'b0), 1'b0));
    run_frame(1'b0, FRAME_BEATS, -1, 20, "full_frame");
    check(src_q.size() == 4, "full_frame_left_in_fifo", 64'(src_q.size()), 4);
    src_q.delete();

    // Random-length bypass frame with arbitrary 64-bit words.
    for (int b = 0; b < 37; b++) src_q.push_back(mk_beat(rand_ops(1'b1), b == 36));
    run_frame(1'b1, 37, -1, -1, "bypass_rand");
    rand_stall = 1'b0; empty_stall = 1'b0; full_mask = 4'hF;

    // Reset in the middle of a streaming frame.
    for (int b = 0; b < 20; b++) src_q.push_back(mk_beat(rand_ops(1'b0), 1'b0));
    err_model = 1'b0; byp_cur = 1'b0; mode_bypass = 1'b0; ap_start = 1'b1;
    drive_inputs();
    tick();
    ap_start = 1'b0;
    r0 = reads; budget = 100;
    while (reads - r0 < 10 && budget > 0) begin tick(); budget--; end
    check(budget > 0, "midreset_reach_10_reads", 64'(budget), 1);
    check(out_write == '1, "midreset_pipeline_busy", 64'(out_write), 15);
    reset = 1'b1;
    @(negedge clk);
    check(ap_idle == 1'b1, "midreset_ap_idle", 64'(ap_idle), 1);
    check(out_write == '0, "midreset_out_write", 64'(out_write), 0);
    check(in_read == '0, "midreset_in_read", 64'(in_read), 0);
    check(beat_count == '0, "midreset_beat_count", 64'(beat_count), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete(); dc_q.delete(); rd_cyc_q.delete();
    r0 = reads; w0 = writes;
    drive_inputs();
    repeat (6) tick();
    check(writes == w0, "after_reset_no_write", 64'(writes - w0), 0);
    check(reads == r0, "after_reset_no_read", 64'(reads - r0), 0);
    src_q.delete();
    for (int b = 0; b < 4; b++) src_q.push_back(mk_beat(rand_ops(1'b0), b == 3));
    run_frame(1'b0, 4, -1, -1, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
